yutorina_bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared Yutorina system bus.
- Four bus masters (CPU IF, CPU MEM, DMA, debug) request ownership; exactly one holds the bus at any time.
- The owner's address drives the slave address decoder.
- Grants are registered, and ownership rotates only when the current owner releases its request (or on watchdog expiry when enabled).

---
 rtl/yutorina_bus_arbiter_pkg.sv | 18 +
 rtl/yutorina_bus_arb_next.sv | 26 ++
 rtl/yutorina_bus_arbiter.sv | 102 ++++++++++
 tb/tb_yutorina_bus_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared bus-arbiter types and constants for the Yutorina system bus.
// The hold-time watchdog is built only when YUTORINA_BUS_ARB_WATCHDOG_EN is defined.
package yutorina_bus_arbiter_pkg;

   typedef logic [1:0] BusOwnerBus;

   localparam BusOwnerBus BUS_OWNER_MASTER_0 = 2'h0;
   localparam BusOwnerBus BUS_OWNER_MASTER_1 = 2'h1;
   localparam BusOwnerBus BUS_OWNER_MASTER_2 = 2'h2;
   localparam BusOwnerBus BUS_OWNER_MASTER_3 = 2'h3;

   localparam int BUS_MASTER_CNT = 4;

   // Active-low strobe levels shared with the rest of the bus
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/yutorina_bus_arb_next.sv
// Combinational round-robin picker: finds the first requester after the
// current owner in rotation order (owner+1, owner+2, owner+3, modulo 4).
module yutorina_bus_arb_next
   import yutorina_bus_arbiter_pkg::*;
(
   input  BusOwnerBus                  owner_i,
   input  logic [BUS_MASTER_CNT-1:0]   req_i,
   output BusOwnerBus                  next_owner_o,
   output logic                        found_o
);

   always_comb begin
      BusOwnerBus cand;
      next_owner_o = owner_i;
      found_o      = 1'b0;
      cand         = owner_i;
      for (int k = 1; k < BUS_MASTER_CNT; k++) begin
         cand = owner_i + BusOwnerBus'(k);
         if (!found_o && req_i[cand]) begin
            next_owner_o = cand;
            found_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Registered round-robin arbiter for four bus masters with parking on the last owner.
// Optional hold-time watchdog enabled by defining YUTORINA_BUS_ARB_WATCHDOG_EN.
module yutorina_bus_arbiter
   import yutorina_bus_arbiter_pkg::*;
#(
   parameter int WATCHDOG_W = 8
)
(
   input  logic       clk,
   input  logic       reset_,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic [1:0] owner,
   output logic       arb_timeout
);

   BusOwnerBus                owner_q, owner_d;
   BusOwnerBus                pickOwner;
   logic                      pickFound;
   logic [BUS_MASTER_CNT-1:0] reqVec;
   logic                      ownerReq;

   assign reqVec   = ~{m3_req_, m2_req_, m1_req_, m0_req_};
   assign ownerReq = reqVec[owner_q];

   yutorina_bus_arb_next u_next (
      .owner_i      (owner_q),
      .req_i        (reqVec),
      .next_owner_o (pickOwner),
      .found_o      (pickFound)
   );

`ifdef YUTORINA_BUS_ARB_WATCHDOG_EN
   localparam logic [WATCHDOG_W-1:0] WD_LIMIT = '1;

   logic [WATCHDOG_W-1:0] wdCnt_q, wdCnt_d;
   logic                  timeout_q, timeout_d;
   logic                  othersReq;

   assign othersReq = |(reqVec & ~(4'b0001 << owner_q));

   // A contended hold that hits the limit is treated exactly like a release
   always_comb begin
      owner_d   = owner_q;
      wdCnt_d   = '0;
      timeout_d = 1'b0;
      if (!ownerReq) begin
         if (pickFound) owner_d = pickOwner;
      end else if (othersReq) begin
         if (wdCnt_q == WD_LIMIT) begin
            owner_d   = pickOwner;
            timeout_d = 1'b1;
         end else begin
            wdCnt_d = wdCnt_q + 1'b1;
         end
      end
      if (owner_d != owner_q) wdCnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset_ == ENABLE_) begin
         owner_q   <= BUS_OWNER_MASTER_0;
         wdCnt_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         owner_q   <= owner_d;
         wdCnt_q   <= wdCnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb_timeout = timeout_q;
`else
   logic [WATCHDOG_W-1:0] unusedWd;
   assign unusedWd = '0;

   always_comb begin
      owner_d = owner_q;
      if (!ownerReq && pickFound) owner_d = pickOwner;
   end

   always_ff @(posedge clk) begin
      if (reset_ == ENABLE_) owner_q <= BUS_OWNER_MASTER_0;
      else                   owner_q <= owner_d;
   end

   assign arb_timeout = 1'b0;
`endif

   assign owner    = owner_q;
   assign m0_grnt_ = (owner_q == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
   assign m1_grnt_ = (owner_q == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
   assign m2_grnt_ = (owner_q == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
   assign m3_grnt_ = (owner_q == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Directed self-checking bench for yutorina_bus_arbiter (watchdog width 4).
// Watchdog expectations follow YUTORINA_BUS_ARB_WATCHDOG_EN.
module tb_yutorina_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset_;
   logic       m0_req_, m1_req_, m2_req_, m3_req_;
   logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
   logic [1:0] owner;
   logic       arb_timeout;

   int checks = 0;
   int errors = 0;

   yutorina_bus_arbiter #(.WATCHDOG_W(4)) dut (
      .clk         (clk),
      .reset_      (reset_),
      .m0_req_     (m0_req_),
      .m1_req_     (m1_req_),
      .m2_req_     (m2_req_),
      .m3_req_     (m3_req_),
      .m0_grnt_    (m0_grnt_),
      .m1_grnt_    (m1_grnt_),
      .m2_grnt_    (m2_grnt_),
      .m3_grnt_    (m3_grnt_),
      .owner       (owner),
      .arb_timeout (arb_timeout)
   );

   always #5 clk = ~clk;

   // reqN is {m3_req_, m2_req_, m1_req_, m0_req_}, active-low
   task automatic applyStimulus(input logic [3:0] reqN, input logic rstN);
      {m3_req_, m2_req_, m1_req_, m0_req_} = reqN;
      reset_ = rstN;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] expOwner, input logic expTimeout);
      logic [3:0] expGrnt;
      logic [3:0] gotGrnt;
      expGrnt = 4'b1111;
      expGrnt[expOwner] = 1'b0;
      gotGrnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
      checks++;
      assert (owner === expOwner) else begin
         errors++;
         $error("[TB] FAIL %s owner: got %0d expected %0d", tag, owner, expOwner);
      end
      checks++;
      assert (gotGrnt === expGrnt) else begin
         errors++;
         $error("[TB] FAIL %s grants: got %b expected %b", tag, gotGrnt, expGrnt);
      end
      checks++;
      assert (arb_timeout === expTimeout) else begin
         errors++;
         $error("[TB] FAIL %s timeout: got %b expected %b", tag, arb_timeout, expTimeout);
      end
   endtask

   initial begin
      // Reset held two cycles with no requests
      applyStimulus(4'b1111, 1'b0);
      tick();
      tick();
      checkOutput("reset", 2'd0, 1'b0);

      // Handover 0 -> 2
      applyStimulus(4'b1110, 1'b1);
      tick();
      checkOutput("m0Holds", 2'd0, 1'b0);
      applyStimulus(4'b1010, 1'b1);
      tick();
      tick();
      checkOutput("m0HoldsContended", 2'd0, 1'b0);
      applyStimulus(4'b1011, 1'b1);
      #2;
      checkOutput("noCombPath", 2'd0, 1'b0);
      tick();
      checkOutput("handoverTo2", 2'd2, 1'b0);

      // Move to owner 1 (m2 releases, only m1 requests: 3,0 skipped)
      applyStimulus(4'b1101, 1'b1);
      tick();
      checkOutput("wrapTo1", 2'd1, 1'b0);

      // Fairness: all request, single-cycle releases give 2,3,0,1
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("allReqHold1", 2'd1, 1'b0);
      applyStimulus(4'b0010, 1'b1);
      tick();
      checkOutput("rr2", 2'd2, 1'b0);
      applyStimulus(4'b0100, 1'b1);
      tick();
      checkOutput("rr3", 2'd3, 1'b0);
      applyStimulus(4'b1000, 1'b1);
      tick();
      checkOutput("rr0", 2'd0, 1'b0);
      applyStimulus(4'b0001, 1'b1);
      tick();
      checkOutput("rr1", 2'd1, 1'b0);

      // Park on 3
      applyStimulus(4'b0111, 1'b1);
      tick();
      checkOutput("to3", 2'd3, 1'b0);
      applyStimulus(4'b1111, 1'b1);
      tick();
      checkOutput("park3a", 2'd3, 1'b0);
      tick();
      checkOutput("park3b", 2'd3, 1'b0);
      applyStimulus(4'b1101, 1'b1);
      tick();
      checkOutput("unpark1", 2'd1, 1'b0);

      // Reset mid-ownership of master 2
      applyStimulus(4'b1011, 1'b1);
      tick();
      checkOutput("to2", 2'd2, 1'b0);
      applyStimulus(4'b1011, 1'b0);
      tick();
      checkOutput("midReset", 2'd0, 1'b0);
      applyStimulus(4'b1011, 1'b1);
      tick();
      checkOutput("afterReset", 2'd2, 1'b0);

      // Watchdog: m0 holds while m1 requests continuously
      applyStimulus(4'b1111, 1'b0);
      tick();
      checkOutput("wdReset", 2'd0, 1'b0);
      applyStimulus(4'b1100, 1'b1);
      for (int i = 0; i < 15; i++) begin
         tick();
         checkOutput($sformatf("wdHold%0d", i), 2'd0, 1'b0);
      end
      tick();
`ifdef YUTORINA_BUS_ARB_WATCHDOG_EN
      checkOutput("wdExpire", 2'd1, 1'b1);
      tick();
      checkOutput("wdPulseEnd", 2'd1, 1'b0);
`else
      checkOutput("noWdHold", 2'd0, 1'b0);
      tick();
      checkOutput("noWdHold2", 2'd0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
